lcd_hd44780_ctrl: RTL and testbench
===================================

Name: lcd_hd44780_ctrl

Overview:
- Character-LCD controller directly downstream of the mini-CPU FSM.
- Consumes the CPU's lcd_update pulse plus opcode/register/value/splash/blank fields and renders two 16-char lines on an HD44780-compatible display (8-bit bus, write-only).
- Reports lcd_busy back to the CPU, which polls it before returning to idle.
- Runs the HD44780 power-up init sequence autonomously after reset.

Parameters:
T_POWERUP, 750000, cycles of wait after reset before the first init command (15 ms @ 50 MHz)
T_EN, 50, cycles lcd_en is held high per byte
T_CMD, 2500, cycles of wait after lcd_en falls, for ordinary bytes
T_CLEAR, 100000, cycles of wait after the clear command 0x01

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset (driven from the CPU's sys_rst_out)
lcd_update  in  1  one-cycle request to redraw the screen
lcd_show_splash  in  1  redraw shows the splash screen
lcd_force_blank  in  1  redraw shows a blank screen
lcd_opcode  in  3  opcode to display
lcd_reg_idx  in  4  destination register to display
lcd_value  in  16  signed result to display
lcd_busy  out  1  high while init or a redraw is in progress
lcd_data  out  8  HD44780 DB7..DB0
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  tied 0 (write only)
lcd_en  out  1  HD44780 enable strobe
lcd_on  out  1  panel power, constant 1

Behaviour:
- Reset, synchronous and active-high:
  - Outputs: lcd_busy=1, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, lcd_on=1.
  - FSM goes to PWR_WAIT and the timer clears.
  - Reset mid-byte drops lcd_en in the next cycle and restarts init.
- States: PWR_WAIT, INIT, IDLE, CONVERT, SETUP, EN_HIGH, HOLD, NEXT.
- PWR_WAIT: count T_POWERUP cycles, then go to INIT.
- INIT: send 0x38, 0x0C, 0x06, 0x01 in that order, all with rs=0, using the byte sequencer. Then go to IDLE with lcd_busy=0.
- Byte sequencer:
  - SETUP: drive lcd_rs and lcd_data for 1 cycle.
  - EN_HIGH: lcd_en=1 for T_EN cycles; data and rs stay stable.
  - HOLD: lcd_en=0 for T_CMD cycles, or T_CLEAR cycles when the byte was 0x01.
  - NEXT: advance the byte index, or finish the sequence.
- IDLE handshake:
  - lcd_update=1 is accepted only in IDLE. All inputs are latched in that same cycle.
  - lcd_busy goes to 1 on the next edge.
  - lcd_update in any other state is ignored. There is no queueing.
- Mode priority (latched): force_blank > show_splash > normal.
  - Blank: send 0x01 only, then return to IDLE.
  - Splash: 0x01, 0x80, line1 "MINI CPU        ", 0xC0, line2 "READY           ".
  - Normal: CONVERT first, then the same frame with the normal text.
    - line1: mnemonic left-justified in 5 chars, then 'R', then 2 decimal digits of reg_idx, padded with spaces to 16.
    - line2: sign char ('+' if value>=0, else '-'), then 5-digit zero-padded magnitude, padded with spaces to 16.
- Mnemonics: 000 LOAD, 001 ADD, 010 ADDI, 011 SUB, 100 SUBI, 101 MUL, 110 CLR, 111 DPL.
- Magnitude:
  - Computed as the 17-bit two's-complement negate of value.
  - -32768 yields 32768 and must not overflow.
- CONVERT:
  - Starts lcd_bin2dec with the magnitude and waits for done.
  - Latency is exactly 17 cycles from start to done.
- Completion: lcd_busy returns to 0 in the cycle after the final HOLD expires, with the FSM in IDLE.
- Character generation: lcd_data for each data byte comes from a combinational mux on (mode, byte index). It is ASCII.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants: CMD_FUNC 0x38, CMD_ON 0x0C, CMD_ENTRY 0x06, CMD_CLEAR 0x01, CMD_LINE1 0x80, CMD_LINE2 0xC0;
  - the state enum;
  - opcode codes, matching the CPU ALU;
  - mnemonic ASCII strings.
- Sub-module lcd_bin2dec: sequential double-dabble, 17-bit in, five BCD digits out, start/done handshake, synchronous reset.

Test Plan:
- Init with T_POWERUP=20, T_EN=2, T_CMD=5, T_CLEAR=10 -> lcd_busy=1 from reset; EN strobes carry 0x38, 0x0C, 0x06, 0x01 with rs=0; lcd_busy=0 afterwards.
- Normal update, opcode=010, reg_idx=3, value=-5 -> bytes 0x01, 0x80, "ADDI R03        ", 0xC0, "-00005          "; rs=1 only on chars; busy drops after the last char.
- Value=0x8000, opcode=101, reg=15 -> "MUL  R15        " / "-32768          "; value=0x7FFF -> "+32767".
- lcd_force_blank=1 together with lcd_show_splash=1 -> only 0x01 is sent; busy is high for about 1+T_EN+T_CLEAR+2 cycles.
- Second lcd_update pulse mid-redraw -> ignored; byte stream identical to the single-update run.
- rst asserted during EN_HIGH of the 10th byte -> lcd_en=0 next cycle, lcd_busy=1, full init sequence repeats.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants, types and character helpers for the HD44780 character-LCD controller.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC  = 8'h38;
  localparam logic [7:0] CMD_ON    = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;

  // Byte index of the last character in a full two-line frame.
  localparam logic [5:0] FRAME_LAST = 6'd34;

  typedef enum logic [2:0] {
    PWR_WAIT, INIT, IDLE, CONVERT, SETUP, EN_HIGH, HOLD, NEXT
  } state_e;

  typedef enum logic [1:0] {
    MODE_INIT, MODE_BLANK, MODE_SPLASH, MODE_NORMAL
  } mode_e;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_SUBI = 3'b100,
    OP_MUL  = 3'b101,
    OP_CLR  = 3'b110,
    OP_DPL  = 3'b111
  } opcode_e;

  localparam logic [39:0] MNEM_LOAD = "LOAD ";
  localparam logic [39:0] MNEM_ADD  = "ADD  ";
  localparam logic [39:0] MNEM_ADDI = "ADDI ";
  localparam logic [39:0] MNEM_SUB  = "SUB  ";
  localparam logic [39:0] MNEM_SUBI = "SUBI ";
  localparam logic [39:0] MNEM_MUL  = "MUL  ";
  localparam logic [39:0] MNEM_CLR  = "CLR  ";
  localparam logic [39:0] MNEM_DPL  = "DPL  ";

  localparam logic [127:0] SPLASH_L1 = "MINI CPU        ";
  localparam logic [127:0] SPLASH_L2 = "READY           ";

  function automatic logic [39:0] mnemonic(input opcode_e op);
    logic [39:0] m;
    m = MNEM_LOAD;
    case (op)
      OP_LOAD: m = MNEM_LOAD;
      OP_ADD:  m = MNEM_ADD;
      OP_ADDI: m = MNEM_ADDI;
      OP_SUB:  m = MNEM_SUB;
      OP_SUBI: m = MNEM_SUBI;
      OP_MUL:  m = MNEM_MUL;
      OP_CLR:  m = MNEM_CLR;
      OP_DPL:  m = MNEM_DPL;
      default: m = MNEM_LOAD;
    endcase
    return m;
  endfunction

  // Character at column pos of a 16-char string, leftmost char in the MSBs.
  function automatic logic [7:0] str_char(input logic [127:0] s, input logic [3:0] pos);
    return s[8*(15-int'(pos)) +: 8];
  endfunction

  function automatic logic [7:0] normal_line1(input opcode_e op, input logic [3:0] reg_idx,
                                              input logic [3:0] pos);
    logic [39:0] m;
    logic [3:0]  ones;
    m    = mnemonic(op);
    ones = (reg_idx >= 4'd10) ? reg_idx - 4'd10 : reg_idx;
    if (pos < 4'd5)  return m[8*(4-int'(pos)) +: 8];
    if (pos == 4'd5) return "R";
    if (pos == 4'd6) return (reg_idx >= 4'd10) ? "1" : "0";
    if (pos == 4'd7) return 8'h30 + {4'h0, ones};
    return " ";
  endfunction

  function automatic logic [7:0] normal_line2(input logic neg, input logic [19:0] digits,
                                              input logic [3:0] pos);
    if (pos == 4'd0) return neg ? "-" : "+";
    if (pos <= 4'd5) return 8'h30 + {4'h0, digits[4*(5-int'(pos)) +: 4]};
    return " ";
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd, input logic b);
    logic [19:0] adj;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    return (adj << 1) | {19'd0, b};
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_if.sv
// CPU-side redraw request and busy handshake of the LCD controller.
interface lcd_hd44780_ctrl_if;
  logic        lcd_update;
  logic        lcd_show_splash;
  logic        lcd_force_blank;
  logic [2:0]  lcd_opcode;
  logic [3:0]  lcd_reg_idx;
  logic [15:0] lcd_value;
  logic        lcd_busy;

  modport master (
    output lcd_update, lcd_show_splash, lcd_force_blank, lcd_opcode, lcd_reg_idx, lcd_value,
    input  lcd_busy
  );

  modport slave (
    input  lcd_update, lcd_show_splash, lcd_force_blank, lcd_opcode, lcd_reg_idx, lcd_value,
    output lcd_busy
  );
endinterface

// File: rtl/lcd_bin2dec.sv
// Sequential double-dabble: 17-bit binary to five BCD digits, done 17 cycles after start.
module lcd_bin2dec
  import lcd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [16:0] bin,
  output logic [19:0] bcd,
  output logic        done
);

  logic [16:0] shreg;
  logic [4:0]  cnt;
  logic        active;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      bcd    <= '0;
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        // The BCD register starts at zero, so the first step needs no add-3 correction.
        bcd    <= {19'd0, bin[16]};
        shreg  <= {bin[15:0], 1'b0};
        cnt    <= 5'd16;
        active <= 1'b1;
      end else if (active) begin
        bcd   <= dabble_step(bcd, shreg[16]);
        shreg <= shreg << 1;
        cnt   <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only controller: power-up init, then blank/splash/status redraws on request.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int T_POWERUP = 750000,
  parameter int T_EN      = 50,
  parameter int T_CMD     = 2500,
  parameter int T_CLEAR   = 100000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_hd44780_ctrl_if.slave  cpu,
  output logic [7:0]         lcd_data,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_en,
  output logic               lcd_on
);

  localparam int T_MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int T_MAX_B = (T_EN > T_CMD) ? T_EN : T_CMD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int TW      = $clog2(T_MAX + 1);

  state_e        state, state_nxt;
  mode_e         mode_q;
  opcode_e       opcode_q;
  logic [3:0]    reg_q;
  logic [15:0]   value_q;
  logic [5:0]    idx, last_idx;
  logic [TW-1:0] timer, limit;
  logic          timer_done;
  logic          conv_go, conv_done;
  logic [16:0]   magnitude;
  logic [19:0]   digits;
  logic [7:0]    byte_val;
  logic          byte_rs;
  logic [3:0]    pos;

  // 17-bit negate keeps -32768 representable as +32768.
  assign magnitude = value_q[15] ? (17'd0 - {1'b1, value_q}) : {1'b0, value_q};

  assign last_idx = (mode_q == MODE_INIT)  ? 6'd3 :
                    (mode_q == MODE_BLANK) ? 6'd0 : FRAME_LAST;

  lcd_bin2dec u_bin2dec (
    .clk   (clk),
    .rst   (rst),
    .start (conv_go),
    .bin   (magnitude),
    .bcd   (digits),
    .done  (conv_done)
  );

  always_comb begin
    limit = '0;
    case (state)
      PWR_WAIT: limit = TW'(T_POWERUP - 1);
      EN_HIGH:  limit = TW'(T_EN - 1);
      HOLD:     limit = (!byte_rs && byte_val == CMD_CLEAR) ? TW'(T_CLEAR - 1) : TW'(T_CMD - 1);
      default:  limit = '0;
    endcase
  end

  assign timer_done = (timer == limit);

  // State register plus the request latch, byte index and phase timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PWR_WAIT;
      timer    <= '0;
      idx      <= '0;
      mode_q   <= MODE_INIT;
      opcode_q <= OP_LOAD;
      reg_q    <= '0;
      value_q  <= '0;
      conv_go  <= 1'b0;
    end else begin
      state   <= state_nxt;
      conv_go <= 1'b0;
      timer   <= (state_nxt != state) ? '0 : timer + 1'b1;
      case (state)
        INIT: begin
          mode_q <= MODE_INIT;
          idx    <= '0;
        end
        IDLE: begin
          if (cpu.lcd_update) begin
            opcode_q <= opcode_e'(cpu.lcd_opcode);
            reg_q    <= cpu.lcd_reg_idx;
            value_q  <= cpu.lcd_value;
            idx      <= '0;
            if (cpu.lcd_force_blank)      mode_q <= MODE_BLANK;
            else if (cpu.lcd_show_splash) mode_q <= MODE_SPLASH;
            else begin
              mode_q  <= MODE_NORMAL;
              conv_go <= 1'b1;
            end
          end
        end
        NEXT: if (idx != last_idx) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PWR_WAIT: if (timer_done) state_nxt = INIT;
      INIT:     state_nxt = SETUP;
      IDLE: begin
        if (cpu.lcd_update)
          state_nxt = (cpu.lcd_force_blank || cpu.lcd_show_splash) ? SETUP : CONVERT;
      end
      CONVERT:  if (conv_done) state_nxt = SETUP;
      SETUP:    state_nxt = EN_HIGH;
      EN_HIGH:  if (timer_done) state_nxt = HOLD;
      HOLD:     if (timer_done) state_nxt = NEXT;
      NEXT:     state_nxt = (idx == last_idx) ? IDLE : SETUP;
      default:  state_nxt = PWR_WAIT;
    endcase
  end

  // Byte generator: command or character for the current (mode, index).
  // NOTE: defaults first so no path through the block leaves a latch.
  always_comb begin
    byte_val = 8'h00;
    byte_rs  = 1'b0;
    pos      = 4'd0;
    case (mode_q)
      MODE_INIT: begin
        case (idx[1:0])
          2'd0:    byte_val = CMD_FUNC;
          2'd1:    byte_val = CMD_ON;
          2'd2:    byte_val = CMD_ENTRY;
          default: byte_val = CMD_CLEAR;
        endcase
      end
      MODE_BLANK: byte_val = CMD_CLEAR;
      default: begin
        if (idx == 6'd0)       byte_val = CMD_CLEAR;
        else if (idx == 6'd1)  byte_val = CMD_LINE1;
        else if (idx == 6'd18) byte_val = CMD_LINE2;
        else if (idx < 6'd18) begin
          byte_rs  = 1'b1;
          pos      = 4'(idx - 6'd2);
          byte_val = (mode_q == MODE_SPLASH) ? str_char(SPLASH_L1, pos)
                                             : normal_line1(opcode_q, reg_q, pos);
        end else begin
          byte_rs  = 1'b1;
          pos      = 4'(idx - 6'd19);
          byte_val = (mode_q == MODE_SPLASH) ? str_char(SPLASH_L2, pos)
                                             : normal_line2(value_q[15], digits, pos);
        end
      end
    endcase
  end

  always_comb begin
    cpu.lcd_busy = (state != IDLE);
    lcd_en       = (state == EN_HIGH);
    lcd_rs       = 1'b0;
    lcd_data     = 8'h00;
    if (state inside {SETUP, EN_HIGH, HOLD}) begin
      lcd_rs   = byte_rs;
      lcd_data = byte_val;
    end
  end

  assign lcd_rw = 1'b0;
  assign lcd_on = 1'b1;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl: init sequence, redraw modes, ignored requests, reset mid-byte.
module tb_lcd_hd44780_ctrl;

  localparam int T_POWERUP = 20;
  localparam int T_EN      = 2;
  localparam int T_CMD     = 5;
  localparam int T_CLEAR   = 10;
  localparam int BUDGET    = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;

  lcd_hd44780_ctrl_if bus ();

  lcd_hd44780_ctrl #(
    .T_POWERUP (T_POWERUP),
    .T_EN      (T_EN),
    .T_CMD     (T_CMD),
    .T_CLEAR   (T_CLEAR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (bus),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_on   (lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] b;
    int         len;
    int         rise;
  } cap_t;

  cap_t       cap[$];
  logic [8:0] want_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rises    = 0;
  int         unstable = 0;
  logic       mon_en_d = 1'b0;
  logic [8:0] mon_cur  = '0;
  int         mon_len  = 0;
  int         mon_rise = 0;

  // Strobe monitor: records {rs,data}, enable width and rise cycle of every byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (lcd_en && !mon_en_d) begin
        mon_cur  = {lcd_rs, lcd_data};
        mon_len  = 1;
        mon_rise = cyc;
        rises++;
      end else if (lcd_en) begin
        mon_len++;
        if ({lcd_rs, lcd_data} !== mon_cur) unstable++;
      end else if (mon_en_d) begin
        cap.push_back('{b: mon_cur, len: mon_len, rise: mon_rise});
      end
      mon_en_d = lcd_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic string pad16(input string s);
    string r;
    r = s;
    while (r.len() < 16) r = {r, " "};
    return r;
  endfunction

  task automatic push_frame(input string l1, input string l2);
    want_q.delete();
    want_q.push_back(9'h001);
    want_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) want_q.push_back({1'b1, l1[i]});
    want_q.push_back(9'h0C0);
    for (int i = 0; i < 16; i++) want_q.push_back({1'b1, l2[i]});
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " byte count"}, 32'(cap.size()), 32'(want_q.size()));
    for (int i = 0; i < want_q.size(); i++) begin
      if (i < cap.size()) begin
        check($sformatf("%s byte%0d", tag, i), 32'(cap[i].b), 32'(want_q[i]));
        check($sformatf("%s en_len%0d", tag, i), 32'(cap[i].len), 32'(T_EN));
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v,
                      input logic splash, input logic blank);
    bus.lcd_opcode      = op;
    bus.lcd_reg_idx     = r;
    bus.lcd_value       = v;
    bus.lcd_show_splash = splash;
    bus.lcd_force_blank = blank;
    bus.lcd_update      = 1'b1;
    @(negedge clk);
    bus.lcd_update      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int cycles);
    cycles = 0;
    while (bus.lcd_busy !== 1'b0 && cycles < BUDGET) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, " idle timeout"}, 32'(cycles >= BUDGET), 32'(0));
  endtask

  initial begin : stim
    int cyc_rel;
    int busy_cycles;
    int base;
    int n;

    rst                 = 1'b1;
    bus.lcd_update      = 1'b0;
    bus.lcd_show_splash = 1'b0;
    bus.lcd_force_blank = 1'b0;
    bus.lcd_opcode      = 3'd0;
    bus.lcd_reg_idx     = 4'd0;
    bus.lcd_value       = 16'd0;
    repeat (3) @(negedge clk);

    check("reset busy", 32'(bus.lcd_busy), 32'(1));
    check("reset en",   32'(lcd_en),       32'(0));
    check("reset rs",   32'(lcd_rs),       32'(0));
    check("reset rw",   32'(lcd_rw),       32'(0));
    check("reset data", 32'(lcd_data),     32'(0));
    check("reset on",   32'(lcd_on),       32'(1));

    // Power-up init
    rst     = 1'b0;
    cyc_rel = cyc;
    wait_idle("init", busy_cycles);
    want_q = {9'h038, 9'h00C, 9'h006, 9'h001};
    compare_stream("init");
    if (cap.size() > 0)
      check("init powerup gap",
            32'((cap[0].rise - cyc_rel >= T_POWERUP) && (cap[0].rise - cyc_rel <= T_POWERUP + 5)),
            32'(1));
    check("init busy low", 32'(bus.lcd_busy), 32'(0));

    // Normal redraw: ADDI R03, -5
    cap.delete();
    send(3'b010, 4'd3, 16'hFFFB, 1'b0, 1'b0);
    check("normal busy after accept", 32'(bus.lcd_busy), 32'(1));
    wait_idle("normal", busy_cycles);
    push_frame(pad16("ADDI R03"), pad16("-00005"));
    compare_stream("normal");

    // Most negative value
    cap.delete();
    send(3'b101, 4'd15, 16'h8000, 1'b0, 1'b0);
    wait_idle("min", busy_cycles);
    push_frame(pad16("MUL  R15"), pad16("-32768"));
    compare_stream("min");

    // Most positive value
    cap.delete();
    send(3'b101, 4'd15, 16'h7FFF, 1'b0, 1'b0);
    wait_idle("max", busy_cycles);
    push_frame(pad16("MUL  R15"), pad16("+32767"));
    compare_stream("max");

    // Splash screen
    cap.delete();
    send(3'b000, 4'd0, 16'd0, 1'b1, 1'b0);
    wait_idle("splash", busy_cycles);
    push_frame(pad16("MINI CPU"), pad16("READY"));
    compare_stream("splash");

    // Blank wins over splash: a single clear command
    cap.delete();
    send(3'b001, 4'd7, 16'd42, 1'b1, 1'b1);
    wait_idle("blank", busy_cycles);
    want_q = {9'h001};
    compare_stream("blank");
    check("blank busy window",
          32'((busy_cycles >= 1 + T_EN + T_CLEAR) && (busy_cycles <= 1 + T_EN + T_CLEAR + 3)),
          32'(1));

    // A second request during a redraw is dropped
    cap.delete();
    send(3'b010, 4'd3, 16'hFFFB, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    send(3'b111, 4'd9, 16'd100, 1'b0, 1'b1);
    wait_idle("ignore", busy_cycles);
    push_frame(pad16("ADDI R03"), pad16("-00005"));
    compare_stream("ignore");
    repeat (40) @(negedge clk);
    check("ignore no queued redraw", 32'(cap.size()), 32'(35));

    // Reset while the 10th byte is strobed restarts the init sequence
    cap.delete();
    base = rises;
    send(3'b010, 4'd3, 16'hFFFB, 1'b0, 1'b0);
    n = 0;
    while (rises != base + 10 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("rst 10th strobe seen", 32'(n < BUDGET), 32'(1));
    check("rst 10th strobe en",   32'(lcd_en),     32'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst mid-byte en",   32'(lcd_en),       32'(0));
    check("rst mid-byte busy", 32'(bus.lcd_busy), 32'(1));
    rst     = 1'b0;
    cyc_rel = cyc;
    cap.delete();
    wait_idle("reinit", busy_cycles);
    want_q = {9'h038, 9'h00C, 9'h006, 9'h001};
    compare_stream("reinit");
    if (cap.size() > 0)
      check("reinit powerup gap",
            32'((cap[0].rise - cyc_rel >= T_POWERUP) && (cap[0].rise - cyc_rel <= T_POWERUP + 5)),
            32'(1));

    check("strobe data stable", 32'(unstable), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
